// File: rtl/cpu_defs.sv
// Shared definitions for the fetch / decode front end of the 5-stage core.
package cpu_defs;

   // D-stage branch/jump operation codes
   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_BEQ  = 3'b001;
   localparam logic [2:0] BR_BNE  = 3'b010;
   localparam logic [2:0] BR_BGEZ = 3'b011;
   localparam logic [2:0] BR_BLTZ = 3'b100;
   localparam logic [2:0] BR_J    = 3'b101;
   localparam logic [2:0] BR_JR   = 3'b110;
   localparam logic [2:0] BR_RSVD = 3'b111;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] NOP          = 32'h0000_0000;

   // Word-scaled, sign-extended 16-bit branch displacement
   function automatic logic [31:0] branch_off(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC resolution for the instruction sitting in D.
module npc_calc
   import cpu_defs::*;
(
   input  logic [31:0] pc_f,
   input  logic [31:0] pc_d,
   input  logic [25:0] instr_idx,
   input  logic [2:0]  br_op,
   input  logic        equal,
   input  logic        bge,
   input  logic [31:0] jr_target,
   output logic        taken,
   output logic [31:0] target,
   output logic [31:0] next_pc,
   output logic        addr_err
);

   logic [31:0] br_tgt;
   logic [31:0] j_tgt;
   logic [31:0] seq_pc;

   // Decode the branch op into a taken flag and its target, then pick next PC
   always_comb begin
      br_tgt = pc_d + 32'd4 + branch_off(instr_idx[15:0]);
      j_tgt  = {pc_d[31:28], instr_idx, 2'b00};
      seq_pc = pc_f + 32'd4;
      taken  = 1'b0;
      target = br_tgt;
      case (br_op)
         BR_BEQ:  taken = equal;
         BR_BNE:  taken = ~equal;
         BR_BGEZ: taken = bge;
         BR_BLTZ: taken = ~bge;
         BR_J: begin
            taken  = 1'b1;
            target = j_tgt;
         end
         BR_JR: begin
            taken  = 1'b1;
            target = jr_target;
         end
         BR_NONE, BR_RSVD: taken = 1'b0;
         default:          taken = 1'b0;
      endcase
      next_pc  = taken ? target : seq_pc;
      // Misaligned target is only flagged; the PC still takes it as-is
      addr_err = taken && (target[1:0] != 2'b00);
   end

endmodule

// File: rtl/fetch_npc_unit.sv
// Fetch PC register and IF/ID pipeline register with D-stage redirect.
module fetch_npc_unit
   import cpu_defs::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter bit          DELAY_SLOT = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr_f,
   input  logic        stall,
   input  logic [2:0]  br_op,
   input  logic        equal,
   input  logic        bge,
   input  logic [31:0] jr_target,
   output logic [31:0] pc_f,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc8_d,
   output logic        taken_d,
   output logic        addr_err
);

   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic [31:0] pcd_q;
   logic [31:0] target;
   logic [31:0] next_pc;

   npc_calc u_npc_calc (
      .pc_f      (pc_q),
      .pc_d      (pcd_q),
      .instr_idx (instr_q[25:0]),
      .br_op     (br_op),
      .equal     (equal),
      .bge       (bge),
      .jr_target (jr_target),
      .taken     (taken_d),
      .target    (target),
      .next_pc   (next_pc),
      .addr_err  (addr_err)
   );

   // PC and IF/ID advance together unless stalled; a stalled branch re-resolves later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP;
         pcd_q   <= RESET_PC;
      end else if (!stall) begin
         pc_q    <= next_pc;
         pcd_q   <= pc_q;
         // Without a delay slot the wrong-path fetch is squashed to a nop
         instr_q <= (!DELAY_SLOT && taken_d) ? NOP : instr_f;
      end
   end

   // Register outputs and link address
   always_comb begin
      pc_f    = pc_q;
      instr_d = instr_q;
      pc_d    = pcd_q;
      pc8_d   = pcd_q + 32'd8;
   end

   logic unused_target;
   assign unused_target = ^target;

endmodule
